// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register file, programmable wait states
// and PSLVERR on misaligned, out-of-range or read-only accesses.
module apb_slave_regfile #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int              IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-3:0] NUM_IDX = (ADDR_W-2)'(NUM_REGS);
  localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]        state_r;
  logic [3:0]        cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic              write_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] prdata_r;
  logic              pready_r;
  logic              pslverr_r;
  logic [DATA_W-1:0] regs_r [NUM_REGS];

  logic              setup_s;
  logic              take_s;
  logic              err_s;
  logic [ADDR_W-3:0] index_s;
  logic [IDX_W-1:0]  sel_s;
  logic [DATA_W-1:0] rd_data_s;

  // A setup phase is accepted from IDLE or directly out of the completion cycle.
  assign setup_s = PSEL & ~PENABLE;
  assign take_s  = setup_s & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign index_s = addr_r[ADDR_W-1:2];
  assign sel_s   = index_s[IDX_W-1:0];

  // Error decode and read mux on the setup-latched address.
  always_comb begin
    err_s     = 1'b0;
    rd_data_s = {DATA_W{1'b0}};
    err_s     = (addr_r[1:0] != 2'b00) | (index_s >= NUM_IDX)
              | (write_r & (index_s == {(ADDR_W-2){1'b0}}));
    if (err_s) begin
      rd_data_s = {DATA_W{1'b0}};
    end else begin
      rd_data_s = regs_r[sel_s];
    end
  end

  // Setup capture and wait-state countdown.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      addr_r  <= {ADDR_W{1'b0}};
      write_r <= 1'b0;
      wdata_r <= {DATA_W{1'b0}};
      cnt_r   <= 4'd0;
    end else if (take_s) begin
      addr_r  <= PADDR;
      write_r <= PWRITE;
      wdata_r <= PWDATA;
      cnt_r   <= WAIT_INIT;
    end else if ((state_r == ST_ACCESS) && PSEL && PENABLE && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Transfer FSM, response registers and register-file commit.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r   <= ST_IDLE;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= {DATA_W{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == 0) begin
          regs_r[i] <= ID_VALUE;
        end else begin
          regs_r[i] <= {DATA_W{1'b0}};
        end
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          pready_r <= 1'b0;
          if (take_s) begin
            pslverr_r <= 1'b0;
            state_r   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            state_r <= ST_IDLE;
          end else if (PENABLE && (cnt_r == 4'd0)) begin
            pready_r  <= 1'b1;
            pslverr_r <= err_s;
            if (write_r) begin
              if (!err_s) begin
                regs_r[sel_s] <= wdata_r;
              end
            end else begin
              prdata_r <= rd_data_s;
            end
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          pready_r <= 1'b0;
          if (take_s) begin
            pslverr_r <= 1'b0;
            state_r   <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          pready_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign PRDATA  = prdata_r;
  assign PREADY  = pready_r;
  assign PSLVERR = pslverr_r;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_W +: DATA_W] = regs_r[g];
  end

endmodule
